// File: rtl/vga_mix_pkg.sv
// ---------------------------------------------------------------------------
// vga_mix_pkg
// Shared types and constants for the VGA layer mixer:
//   DEFAULT_RGB_W      default pixel width (3 equal channels)
//   MAX_LAYERS         largest supported layer count
//   rgb_t              pixel type at the default width
//   DEFAULT_KEY_COLOR  default transparent colour key
//   timing_t           bundled VGA timing signals carried through the pipe
//   TIMING_W           packed width of timing_t
// ---------------------------------------------------------------------------
package vga_mix_pkg;

  localparam int DEFAULT_RGB_W = 12;
  localparam int MAX_LAYERS    = 8;

  typedef logic [DEFAULT_RGB_W-1:0] rgb_t;

  localparam rgb_t DEFAULT_KEY_COLOR = 12'hF0F;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  localparam int TIMING_W = $bits(timing_t);

endpackage

// File: rtl/vga_mix_delay.sv
// ---------------------------------------------------------------------------
// vga_mix_delay
// Fixed-depth delay line for the VGA timing bundle, keeping the timing
// outputs aligned with the pixel pipeline.
// Ports:
//   clk         pixel clock
//   rst         asynchronous active-low reset (clears every stage)
//   timing_in   packed timing_t from the timing generator
//   timing_out  the same bundle delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module vga_mix_delay
  import vga_mix_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TIMING_W-1:0] timing_in,
  output logic [TIMING_W-1:0] timing_out
);

  timing_t pipe_q [DEPTH];
  timing_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = timing_t'(timing_in);
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign timing_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_layer_mixer.sv
// ---------------------------------------------------------------------------
// vga_layer_mixer
// N-layer priority pixel compositor with colour-key transparency,
// frame-synchronous layer enables, per-frame overlap report and frame count.
// Two-stage pipeline: stage 1 registers the inputs, stage 2 selects and
// registers the result; timing passes through a matching 2-deep delay.
// Optional feature macro: VGA_MIX_BLEND_EN -- layers flagged in BLEND_MASK
// are averaged per channel with the composite beneath them. Without the
// macro all layers are opaque and BLEND_MASK is ignored.
// Ports:
//   clk, rst                 pixel clock, asynchronous active-low reset
//   hcount_in..vblnk_in      timing inputs
//   bg_rgb                   background pixel
//   layer_rgb, layer_valid   per-layer pixel and coverage (layer i at i*RGB_W)
//   layer_en_req             enable mask applied at the next frame start
//   hcount_out..vblnk_out    timing delayed by 2 cycles
//   rgb_out                  composited pixel
//   layer_en                 active enable mask
//   overlap_frame            layers that overlapped in the previous frame
//   frame_cnt                completed-frame counter (wraps)
// ---------------------------------------------------------------------------
module vga_layer_mixer
  import vga_mix_pkg::*;
#(
  parameter int                   NUM_LAYERS = 4,
  parameter int                   RGB_W      = 12,
  parameter logic [RGB_W-1:0]     KEY_COLOR  = DEFAULT_KEY_COLOR,
  parameter logic [NUM_LAYERS-1:0] RESET_MASK = '1,
  parameter logic [NUM_LAYERS-1:0] BLEND_MASK = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [10:0]                 hcount_in,
  input  logic [10:0]                 vcount_in,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        hblnk_in,
  input  logic                        vblnk_in,
  input  logic [RGB_W-1:0]            bg_rgb,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_valid,
  input  logic [NUM_LAYERS-1:0]       layer_en_req,
  output logic [10:0]                 hcount_out,
  output logic [10:0]                 vcount_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        hblnk_out,
  output logic                        vblnk_out,
  output logic [RGB_W-1:0]            rgb_out,
  output logic [NUM_LAYERS-1:0]       layer_en,
  output logic [NUM_LAYERS-1:0]       overlap_frame,
  output logic [15:0]                 frame_cnt
);

`ifdef VGA_MIX_BLEND_EN
  localparam int CH_W = RGB_W / 3;
`else
  logic unused_blend_mask;
  assign unused_blend_mask = ^BLEND_MASK;
`endif

  timing_t timing_in_s;
  timing_t timing_out_s;

  // Stage-1 registers
  logic [RGB_W-1:0]            bg_s1_q, bg_s1_d;
  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb_s1_q, layer_rgb_s1_d;
  logic [NUM_LAYERS-1:0]       layer_valid_s1_q, layer_valid_s1_d;
  logic [NUM_LAYERS-1:0]       layer_en_req_s1_q, layer_en_req_s1_d;
  logic                        blank_s1_q, blank_s1_d;
  logic                        vsync_s1_q, vsync_s1_d;
  logic                        vsync_s2_q, vsync_s2_d;

  // Stage-2 / frame state
  logic [RGB_W-1:0]      rgb_out_q, rgb_out_d;
  logic [NUM_LAYERS-1:0] layer_en_q, layer_en_d;
  logic [NUM_LAYERS-1:0] overlap_frame_q, overlap_frame_d;
  logic [NUM_LAYERS-1:0] overlap_acc_q, overlap_acc_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  logic [NUM_LAYERS-1:0] visible;
  logic [NUM_LAYERS-1:0] overlap_set;
  logic [RGB_W-1:0]      composite;
  logic                  frame_start;

  always_comb begin
    timing_in_s.hcount = hcount_in;
    timing_in_s.vcount = vcount_in;
    timing_in_s.hsync  = hsync_in;
    timing_in_s.vsync  = vsync_in;
    timing_in_s.hblnk  = hblnk_in;
    timing_in_s.vblnk  = vblnk_in;
  end

  vga_mix_delay #(
    .DEPTH (2)
  ) u_timing_delay (
    .clk        (clk),
    .rst        (rst),
    .timing_in  (timing_in_s),
    .timing_out (timing_out_s)
  );

  always_comb begin
    bg_s1_d           = bg_rgb;
    layer_rgb_s1_d    = layer_rgb;
    layer_valid_s1_d  = layer_valid;
    layer_en_req_s1_d = layer_en_req;
    blank_s1_d        = hblnk_in | vblnk_in;
    vsync_s1_d        = vsync_in;
    vsync_s2_d        = vsync_s1_q;
  end

  always_comb begin
    visible = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      visible[i] = layer_valid_s1_q[i] & layer_en_q[i] &
                   (layer_rgb_s1_q[i*RGB_W +: RGB_W] != KEY_COLOR);
    end
  end

  // Walk from lowest to highest priority so the last visible layer wins;
  // a blended layer averages with whatever has been composited below it.
  always_comb begin
    composite = bg_s1_q;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (visible[i]) begin
`ifdef VGA_MIX_BLEND_EN
        if (BLEND_MASK[i]) begin
          for (int c = 0; c < 3; c++) begin
            composite[c*CH_W +: CH_W] = CH_W'(({1'b0, layer_rgb_s1_q[i*RGB_W + c*CH_W +: CH_W]} +
                                               {1'b0, composite[c*CH_W +: CH_W]}) >> 1);
          end
        end else begin
          composite = layer_rgb_s1_q[i*RGB_W +: RGB_W];
        end
`else
        composite = layer_rgb_s1_q[i*RGB_W +: RGB_W];
`endif
      end
    end
  end

  // Rising edge of the registered vsync marks the frame boundary. Overlap is
  // only counted in active video when two or more layers are visible
  // (x & (x-1) is non-zero exactly when at least two bits are set).
  always_comb begin
    frame_start     = vsync_s1_q & ~vsync_s2_q;
    overlap_set     = '0;
    if (!blank_s1_q && ((visible & (visible - 1'b1)) != '0)) begin
      overlap_set = visible;
    end
    rgb_out_d       = blank_s1_q ? '0 : composite;
    layer_en_d      = layer_en_q;
    overlap_frame_d = overlap_frame_q;
    overlap_acc_d   = overlap_acc_q | overlap_set;
    frame_cnt_d     = frame_cnt_q;
    if (frame_start) begin
      layer_en_d      = layer_en_req_s1_q;
      overlap_frame_d = overlap_acc_q;
      overlap_acc_d   = overlap_set;
      frame_cnt_d     = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bg_s1_q           <= '0;
      layer_rgb_s1_q    <= '0;
      layer_valid_s1_q  <= '0;
      layer_en_req_s1_q <= '0;
      blank_s1_q        <= 1'b0;
      vsync_s1_q        <= 1'b0;
      vsync_s2_q        <= 1'b0;
      rgb_out_q         <= '0;
      layer_en_q        <= RESET_MASK;
      overlap_frame_q   <= '0;
      overlap_acc_q     <= '0;
      frame_cnt_q       <= '0;
    end else begin
      bg_s1_q           <= bg_s1_d;
      layer_rgb_s1_q    <= layer_rgb_s1_d;
      layer_valid_s1_q  <= layer_valid_s1_d;
      layer_en_req_s1_q <= layer_en_req_s1_d;
      blank_s1_q        <= blank_s1_d;
      vsync_s1_q        <= vsync_s1_d;
      vsync_s2_q        <= vsync_s2_d;
      rgb_out_q         <= rgb_out_d;
      layer_en_q        <= layer_en_d;
      overlap_frame_q   <= overlap_frame_d;
      overlap_acc_q     <= overlap_acc_d;
      frame_cnt_q       <= frame_cnt_d;
    end
  end

  assign hcount_out    = timing_out_s.hcount;
  assign vcount_out    = timing_out_s.vcount;
  assign hsync_out     = timing_out_s.hsync;
  assign vsync_out     = timing_out_s.vsync;
  assign hblnk_out     = timing_out_s.hblnk;
  assign vblnk_out     = timing_out_s.vblnk;
  assign rgb_out       = rgb_out_q;
  assign layer_en      = layer_en_q;
  assign overlap_frame = overlap_frame_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
